red_pitaya_fads_sorter: RTL

RED_PITAYA_FADS_SORTER -- requirements
Module: red_pitaya_fads_sorter

---
 rtl/red_pitaya_fads_sorter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_fads_sorter.sv
// FADS sort-pulse scheduler.
// Each rising edge of sort_req_i (while enabled) queues a due time of
// tick + delay. When the head entry comes due, the block drives a bipolar
// square-wave burst on dac_o with hv_gate_o high, then waits holdoff cycles.
// Ports:
//   adc_clk_i, adc_rstn_i     clock, asynchronous active-low reset
//   sort_req_i                sort request level (rising edge = request)
//   dac_o, hv_gate_o          registered burst waveform and gate
//   busy_o                    scheduler active or requests pending
//   sys_*                     register bus (one-cycle ack, err tied low)
module red_pitaya_fads_sorter #(
  parameter int FSZ = 3,
  parameter int DWT = 14
) (
  input  logic                  adc_clk_i,
  input  logic                  adc_rstn_i,
  input  logic                  sort_req_i,
  output logic signed [DWT-1:0] dac_o,
  output logic                  hv_gate_o,
  output logic                  busy_o,
  input  logic [31:0]           sys_addr,
  input  logic [31:0]           sys_wdata,
  input  logic [3:0]            sys_sel,
  input  logic                  sys_wen,
  input  logic                  sys_ren,
  output logic [31:0]           sys_rdata,
  output logic                  sys_err,
  output logic                  sys_ack
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PULSE, S_GAP} state_t;
  localparam int DEPTH = 1 << FSZ;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic        enable;
  logic [31:0] delay, duration, half_period, amplitude, holdoff;
  logic [31:0] tick, pulses_cnt, dropped_cnt, late_cnt;
  logic [31:0] dur_cnt, hp_cnt, gap_cnt;
  state_t      state;

  logic [19:0] addr;
  logic        clr;
  assign addr = sys_addr[19:0];
  // Clear acts on the same edge that accepts the write.
  assign clr  = sys_wen && (addr == 20'h0) && sys_wdata[1];

  // Configuration registers
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      enable      <= 1'b1;
      delay       <= 32'd31250;
      duration    <= 32'd125000;
      half_period <= 32'd2500;
      amplitude   <= 32'd4000;
      holdoff     <= 32'd1250;
    end else if (sys_wen) begin
      case (addr)
        20'h00: enable      <= sys_wdata[0];
        20'h04: delay       <= sys_wdata;
        20'h08: duration    <= sys_wdata;
        20'h0C: half_period <= sys_wdata;
        20'h10: amplitude   <= sys_wdata;
        20'h14: holdoff     <= sys_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) tick <= '0;
    else             tick <= tick + 32'd1;
  end

  // Registered edge detect: request is acted on one cycle after the edge.
  logic req_q, edge_q;
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      req_q  <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      req_q  <= sort_req_i;
      edge_q <= clr ? 1'b0 : (sort_req_i && !req_q);
    end
  end

  // Pending-sort FIFO of absolute due times
  logic [31:0]    mem [DEPTH];
  logic [FSZ-1:0] wr_ptr, rd_ptr;
  logic [FSZ:0]   level;
  logic           full, empty, push, drop, fire, late;
  logic [31:0]    diff;

  assign full  = (level == (FSZ+1)'(DEPTH));
  assign empty = (level == '0);
  assign push  = edge_q && enable && !full;
  assign drop  = edge_q && enable && full;
  // Wrap-safe due check: fire once signed (tick - due) is non-negative.
  assign diff  = tick - mem[rd_ptr];
  assign fire  = (state == S_WAIT) && !empty && !diff[31];
  assign late  = fire && (diff != 32'd0);

  always_ff @(posedge adc_clk_i) begin
    if (push) mem[wr_ptr] <= tick + delay;
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (FSZ)'(1);
      if (fire) rd_ptr <= rd_ptr + (FSZ)'(1);
      case ({push, fire})
        2'b10:   level <= level + (FSZ+1)'(1);
        2'b01:   level <= level - (FSZ+1)'(1);
        default: ;
      endcase
    end
  end

  // Burst scheduler
  logic [31:0]           dur_eff, hp_eff;
  logic signed [DWT-1:0] amp_eff;
  assign dur_eff = (duration == '0) ? 32'd1 : duration;
  assign hp_eff  = (half_period == '0) ? 32'd1 : half_period;
  // Top bit forced to zero so -amp_eff always fits.
  assign amp_eff = {1'b0, amplitude[DWT-2:0]};

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state       <= S_IDLE;
      dac_o       <= '0;
      hv_gate_o   <= 1'b0;
      dur_cnt     <= '0;
      hp_cnt      <= '0;
      gap_cnt     <= '0;
      pulses_cnt  <= '0;
      dropped_cnt <= '0;
      late_cnt    <= '0;
    end else if (clr) begin
      state       <= S_IDLE;
      dac_o       <= '0;
      hv_gate_o   <= 1'b0;
      pulses_cnt  <= '0;
      dropped_cnt <= '0;
      late_cnt    <= '0;
    end else begin
      if (drop) dropped_cnt <= sat_inc(dropped_cnt);
      case (state)
        S_IDLE: if (!empty) state <= S_WAIT;
        S_WAIT: if (fire) begin
          dur_cnt   <= dur_eff;
          hp_cnt    <= hp_eff;
          dac_o     <= amp_eff;
          hv_gate_o <= 1'b1;
          state     <= S_PULSE;
          if (late) late_cnt <= sat_inc(late_cnt);
        end
        S_PULSE: begin
          if (dur_cnt == 32'd1) begin
            dac_o      <= '0;
            hv_gate_o  <= 1'b0;
            pulses_cnt <= sat_inc(pulses_cnt);
            gap_cnt    <= holdoff;
            state      <= (holdoff == '0) ? S_IDLE : S_GAP;
          end else begin
            dur_cnt <= dur_cnt - 32'd1;
            if (hp_cnt == 32'd1) begin
              dac_o  <= -dac_o;
              hp_cnt <= hp_eff;
            end else begin
              hp_cnt <= hp_cnt - 32'd1;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt <= 32'd1) state <= S_IDLE;
          else                  gap_cnt <= gap_cnt - 32'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state != S_IDLE) || !empty;

  // Register read-back
  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (addr)
      20'h000: rd_mux = {31'd0, enable};
      20'h004: rd_mux = delay;
      20'h008: rd_mux = duration;
      20'h00C: rd_mux = half_period;
      20'h010: rd_mux = amplitude;
      20'h014: rd_mux = holdoff;
      20'h100: rd_mux = pulses_cnt;
      20'h104: rd_mux = dropped_cnt;
      20'h108: rd_mux = late_cnt;
      20'h10C: rd_mux = 32'(level);
      20'h110: rd_mux = {30'd0, state};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack   <= sys_wen || sys_ren;
      sys_err   <= 1'b0;
      sys_rdata <= sys_ren ? rd_mux : 32'd0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{sys_sel, sys_addr[31:20], amplitude[31:DWT-1]};

endmodule
